// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared state encoding and latency-counter sizing for the boot stream loader
package boot_loader_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, FINISH, EXEC} state_t;
  function automatic int lat_w(input int lat);
    return $clog2(lat + 1);
  endfunction
  localparam int ROM_LAT_W = lat_w(1);
endpackage

// File: rtl/boot_stream_loader.sv
// boot_stream_loader: copies a ROM block into the core download port, then optionally requests execution
module boot_stream_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int ROM_LAT = 1,
  parameter int AUTO_EXEC = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  input  logic              start_exec,
  input  logic [ADDR_W-1:0] exec_target,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              dn_wait,
  output logic              dn_go,
  output logic              dn_wr,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [DATA_W-1:0] dn_data,
  output logic              exec_en,
  output logic [ADDR_W-1:0] exec_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);
  localparam int LW = lat_w(ROM_LAT);
  localparam logic [LW-1:0] LAT = LW'(ROM_LAT);
  state_t state, state_nx;
  logic [ADDR_W-1:0] src, dst, left;
  logic [LW-1:0] cnt;
  logic exec_req, launch, fetched, accept;
  assign rom_addr = src;
  assign dn_addr = dst;
  // next-state decode and state-derived strobes; the ROM address only moves after an accept
  always_comb begin
    launch = state == IDLE && start;
    fetched = state == FETCH && cnt == '0;
    accept = state == WRITE && !dn_wait;
    dn_go = state == FETCH || state == WRITE;
    dn_wr = state == WRITE;
    busy = state != IDLE;
    done = state == FINISH;
    exec_en = state == EXEC;
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = length == '0 ? FINISH : FETCH;
      FETCH:   if (fetched) state_nx = WRITE;
      WRITE:   if (accept) state_nx = left == ADDR_W'(1) ? FINISH : FETCH;
      FINISH:  state_nx = exec_req ? EXEC : IDLE;
      EXEC:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register; reset aborts any copy on the same edge
  always_ff @(posedge clk_sys) state <= !reset_n ? IDLE : state_nx;
  // operand latch, ROM latency countdown, write data capture and running checksum
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      src <= '0;
      dst <= '0;
      left <= '0;
      cnt <= '0;
      dn_data <= '0;
      checksum <= '0;
      exec_addr <= '0;
      exec_req <= 1'b0;
    end else begin
      if (launch) begin
        src <= src_base;
        dst <= dst_base;
        left <= length;
        cnt <= LAT;
        checksum <= '0;
        exec_addr <= exec_target;
        exec_req <= start_exec && AUTO_EXEC != 0;
      end
      if (state == FETCH && !fetched) cnt <= cnt - LW'(1);
      if (fetched) dn_data <= rom_data;
      if (accept) begin
        checksum <= checksum + dn_data;
        src <= src + ADDR_W'(1);
        dst <= dst + ADDR_W'(1);
        left <= left - ADDR_W'(1);
        cnt <= LAT;
      end
    end
  end
endmodule

// File: tb/tb_boot_stream_loader.sv
// tb_boot_stream_loader: runs ROM_LAT=1 and ROM_LAT=3 loaders side by side against a cycle-schedule model
module tb_boot_stream_loader;
  logic clk_sys = 0, reset_n = 0, start = 0, start_exec = 0, dn_wait = 0;
  logic [15:0] src_base = 0, dst_base = 0, length = 0, exec_target = 0;
  logic [15:0] rom_addr [2], dn_addr [2], exec_addr [2];
  logic [7:0] rom_data [2], dn_data [2], checksum [2];
  logic dn_go [2], dn_wr [2], exec_en [2], busy [2], done [2];
  always #5 clk_sys = ~clk_sys;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    boot_stream_loader #(.ADDR_W(16), .DATA_W(8), .ROM_LAT(g == 0 ? 1 : 3), .AUTO_EXEC(1)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .src_base(src_base), .dst_base(dst_base),
      .length(length), .start_exec(start_exec), .exec_target(exec_target), .rom_addr(rom_addr[g]),
      .rom_data(rom_data[g]), .dn_wait(dn_wait), .dn_go(dn_go[g]), .dn_wr(dn_wr[g]), .dn_addr(dn_addr[g]),
      .dn_data(dn_data[g]), .exec_en(exec_en[g]), .exec_addr(exec_addr[g]), .busy(busy[g]), .done(done[g]),
      .checksum(checksum[g]));
  end
  function automatic int lat(input int l);
    return l == 0 ? 1 : 3;
  endfunction
  // synchronous ROM with per-lane read latency
  logic [7:0] mem [65536];
  logic [7:0] pipe [2][3];
  always @(posedge clk_sys)
    for (int l = 0; l < 2; l++) begin
      pipe[l][0] <= mem[rom_addr[l]];
      pipe[l][1] <= pipe[l][0];
      pipe[l][2] <= pipe[l][1];
    end
  assign rom_data[0] = pipe[0][0];
  assign rom_data[1] = pipe[1][2];
  // reference: a strobe appears lat+1 edges after start/accept, held until a cycle with dn_wait low
  bit m_busy [2], m_go [2], m_wr [2], m_done [2], m_exec [2], xreq [2];
  logic [15:0] m_addr [2], m_src [2], m_dst [2], m_left [2], m_xaddr [2];
  logic [7:0] m_data [2], m_sum [2];
  int cd [2];
  always @(posedge clk_sys)
    for (int l = 0; l < 2; l++) begin
      if (!reset_n) begin
        m_busy[l] = 0; m_go[l] = 0; m_wr[l] = 0; m_done[l] = 0; m_exec[l] = 0; xreq[l] = 0;
        m_addr[l] = 0; m_src[l] = 0; m_dst[l] = 0; m_left[l] = 0; m_xaddr[l] = 0;
        m_data[l] = 0; m_sum[l] = 0; cd[l] = 0;
      end else begin
        bit idle, acc, nd, nx;
        idle = !m_busy[l];
        acc = m_wr[l] && !dn_wait;
        nd = 0;
        nx = 0;
        if (m_exec[l] || (m_done[l] && !xreq[l])) m_busy[l] = 0;
        if (m_done[l] && xreq[l]) nx = 1;
        if (cd[l] > 0) begin
          cd[l]--;
          if (cd[l] == 0) begin
            m_wr[l] = 1;
            m_addr[l] = m_dst[l];
            m_data[l] = mem[m_src[l]];
          end
        end
        if (acc) begin
          m_sum[l] += m_data[l];
          m_src[l]++;
          m_dst[l]++;
          m_left[l]--;
          m_wr[l] = 0;
          if (m_left[l] == 0) begin
            m_go[l] = 0;
            nd = 1;
          end else cd[l] = lat(l) + 1;
        end
        if (idle && start) begin
          m_src[l] = src_base; m_dst[l] = dst_base; m_left[l] = length; m_sum[l] = 0;
          m_xaddr[l] = exec_target; xreq[l] = start_exec; m_busy[l] = 1;
          if (length == 0) nd = 1;
          else begin
            m_go[l] = 1;
            cd[l] = lat(l) + 1;
          end
        end
        m_done[l] = nd;
        m_exec[l] = nx;
      end
    end
  int errs = 0, nchk = 0, cyc = 0;
  bit chk_on = 0;
  task automatic chk(input string n, input int l, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL lane%0d %s: got %0h expected %0h (cycle %0d)", l, n, got, exp, cyc);
    end
  endtask
  logic [15:0] log_a [2][512];
  logic [7:0] log_d [2][512];
  int log_c [2][512], log_h [2][512];
  int nlog [2] = '{0, 0}, ndone [2] = '{0, 0}, nexec [2] = '{0, 0}, ngo [2] = '{0, 0};
  int dcyc [2], xcyc [2];
  logic [15:0] lastx [2];
  bit pwr [2];
  // per-cycle comparison against the model plus an event log for the directed checks
  always @(negedge clk_sys) begin
    cyc++;
    for (int l = 0; l < 2; l++) begin
      if (chk_on) begin
        chk("busy", l, busy[l], m_busy[l]);
        chk("dn_go", l, dn_go[l], m_go[l]);
        chk("dn_wr", l, dn_wr[l], m_wr[l]);
        chk("done", l, done[l], m_done[l]);
        chk("exec_en", l, exec_en[l], m_exec[l]);
        if (m_go[l]) chk("rom_addr", l, rom_addr[l], m_src[l]);
        if (m_wr[l]) chk("dn_addr", l, dn_addr[l], m_addr[l]);
        if (m_wr[l]) chk("dn_data", l, dn_data[l], m_data[l]);
        if (m_exec[l]) chk("exec_addr", l, exec_addr[l], m_xaddr[l]);
        if (!m_busy[l] || m_done[l]) chk("checksum", l, checksum[l], m_sum[l]);
      end
      if (dn_wr[l] && !pwr[l] && nlog[l] < 512) begin
        log_a[l][nlog[l]] = dn_addr[l];
        log_d[l][nlog[l]] = dn_data[l];
        log_c[l][nlog[l]] = cyc;
        log_h[l][nlog[l]] = 0;
        nlog[l]++;
      end
      if (dn_wr[l] && nlog[l] > 0) log_h[l][nlog[l]-1]++;
      pwr[l] = dn_wr[l];
      if (dn_go[l]) ngo[l]++;
      if (done[l]) begin ndone[l]++; dcyc[l] = cyc; end
      if (exec_en[l]) begin nexec[l]++; xcyc[l] = cyc; lastx[l] = exec_addr[l]; end
    end
  end
  task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n, input logic x,
                    input logic [15:0] t);
    @(negedge clk_sys);
    start = 1; src_base = s; dst_base = d; length = n; start_exec = x; exec_target = t;
    @(negedge clk_sys);
    start = 0; src_base = 16'($urandom); dst_base = 16'($urandom); length = 16'($urandom);
    start_exec = 1'($urandom); exec_target = 16'($urandom);
  endtask
  task automatic settle(input bit rnd);
    int k = 0;
    while ((busy[0] || busy[1]) && k < 300) begin
      @(negedge clk_sys);
      dn_wait = rnd ? $urandom_range(0, 3) == 0 : 1'b0;
      k++;
    end
    dn_wait = 0;
    chk("settle idle", 0, {busy[0], busy[1]}, 0);
    @(negedge clk_sys);
    #1;
  endtask
  task automatic wait_word2(input int b);
    int k = 0;
    while (nlog[0] - b < 2 && k < 60) begin
      @(negedge clk_sys);
      #1;
      k++;
    end
    chk("reach word2", 0, nlog[0] - b, 2);
  endtask
  int b [2], bd [2], bx [2], bg [2];
  task automatic snap();
    b = nlog; bd = ndone; bx = nexec; bg = ngo;
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) mem[16+i] = 8'(i + 1);
    repeat (3) @(negedge clk_sys);
    chk_on = 1;
    for (int l = 0; l < 2; l++) begin
      chk("rst busy", l, busy[l], 0);
      chk("rst dn_go", l, dn_go[l], 0);
      chk("rst rom_addr", l, rom_addr[l], 0);
      chk("rst checksum", l, checksum[l], 0);
    end
    reset_n = 1;
    snap();
    go(16'h10, 16'h100, 4, 0, 0);
    settle(0);
    for (int l = 0; l < 2; l++) begin
      chk("t1 writes", l, nlog[l] - b[l], 4);
      chk("t1 done", l, ndone[l] - bd[l], 1);
      chk("t1 checksum", l, checksum[l], 8'h0A);
      chk("t1 model sum", l, m_sum[l], 8'h0A);
      for (int i = 0; i < 4; i++) begin
        chk("t1 addr", l, log_a[l][b[l]+i], 16'h100 + 16'(i));
        chk("t1 data", l, log_d[l][b[l]+i], 8'(i + 1));
        if (i > 0) chk("t1 spacing", l, log_c[l][b[l]+i] - log_c[l][b[l]+i-1], lat(l) + 2);
      end
    end
    snap();
    go(16'h0, 16'h0, 0, 1, 16'h1234);
    settle(0);
    for (int l = 0; l < 2; l++) begin
      chk("t2 writes", l, nlog[l] - b[l], 0);
      chk("t2 dn_go cycles", l, ngo[l] - bg[l], 0);
      chk("t2 done", l, ndone[l] - bd[l], 1);
      chk("t2 exec", l, nexec[l] - bx[l], 1);
      chk("t2 exec delay", l, xcyc[l] - dcyc[l], 1);
      chk("t2 exec_addr", l, lastx[l], 16'h1234);
    end
    snap();
    go(16'h10, 16'h100, 4, 0, 0);
    wait_word2(b[0]);
    dn_wait = 1;
    repeat (5) @(negedge clk_sys);
    dn_wait = 0;
    settle(0);
    chk("t3 writes", 0, nlog[0] - b[0], 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3 data", 0, log_d[0][b[0]+i], 8'(i + 1));
      chk("t3 addr", 0, log_a[0][b[0]+i], 16'h100 + 16'(i));
      chk("t3 strobe len", 0, log_h[0][b[0]+i], i == 1 ? 6 : 1);
    end
    for (int l = 0; l < 2; l++) chk("t3 checksum", l, checksum[l], 8'h0A);
    snap();
    go(16'h20, 16'hFFFE, 3, 0, 0);
    settle(1);
    for (int l = 0; l < 2; l++) begin
      chk("t4 writes", l, nlog[l] - b[l], 3);
      chk("t4 addr0", l, log_a[l][b[l]], 16'hFFFE);
      chk("t4 addr1", l, log_a[l][b[l]+1], 16'hFFFF);
      chk("t4 addr2", l, log_a[l][b[l]+2], 16'h0000);
    end
    snap();
    go(16'h40, 16'h200, 8, 1, 16'h55AA);
    wait_word2(b[0]);
    reset_n = 0;
    @(negedge clk_sys);
    for (int l = 0; l < 2; l++) begin
      chk("t5 busy", l, busy[l], 0);
      chk("t5 dn_go", l, dn_go[l], 0);
      chk("t5 dn_wr", l, dn_wr[l], 0);
      chk("t5 dn_addr", l, dn_addr[l], 0);
      chk("t5 exec_addr", l, exec_addr[l], 0);
      chk("t5 checksum", l, checksum[l], 0);
    end
    reset_n = 1;
    go(16'h10, 16'h100, 4, 0, 0);
    settle(0);
    for (int l = 0; l < 2; l++) begin
      chk("t5 done", l, ndone[l] - bd[l], 1);
      chk("t5 exec", l, nexec[l] - bx[l], 0);
      chk("t5 rerun checksum", l, checksum[l], 8'h0A);
    end
    snap();
    go(16'h10, 16'h300, 4, 0, 0);
    repeat (6) @(negedge clk_sys);
    go(16'h80, 16'h900, 5, 1, 16'h1111);
    settle(0);
    for (int l = 0; l < 2; l++) begin
      chk("t6 writes", l, nlog[l] - b[l], 4);
      chk("t6 done", l, ndone[l] - bd[l], 1);
      chk("t6 exec", l, nexec[l] - bx[l], 0);
      chk("t6 checksum", l, checksum[l], 8'h0A);
      for (int i = 0; i < 4; i++) begin
        chk("t6 addr", l, log_a[l][b[l]+i], 16'h300 + 16'(i));
        if (i > 0) chk("t6 spacing", l, log_c[l][b[l]+i] - log_c[l][b[l]+i-1], lat(l) + 2);
      end
    end
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_sys);
      dn_wait = $urandom_range(0, 3) == 0;
      start = $urandom_range(0, 9) == 0;
      src_base = 16'($urandom);
      dst_base = 16'($urandom);
      length = 16'($urandom_range(0, 5));
      start_exec = 1'($urandom);
      exec_target = 16'($urandom);
      reset_n = $urandom_range(0, 199) != 0;
    end
    @(negedge clk_sys);
    start = 0;
    reset_n = 1;
    settle(0);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
